// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Sequences the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and
//   the PC. Per-latch enable/flush are decided combinationally from the current
//   state and this cycle's handshakes. They take effect at the next rising edge.
//
// Optional feature: define PIPELINE_PERF_CNT_EN to add the stall_cycles and
//   redirects performance counters and the CNT_W parameter.
//
// Parameters
//   STALL_LIMIT   consecutive DSTALL cycles before stall_timeout asserts (>=1)
//   CNT_W         perf counter width (PIPELINE_PERF_CNT_EN only)
// Ports
//   CLK, RST                       clock (rising edge), async active-high reset
//   ihit, dhit                     I-fetch / data access complete this cycle
//   exmem_dren/dwen/halt           EX/MEM holds load / store / HALT
//   br_taken                       redirect resolved taken in MEM
//   idex_dren, idex_rt             load and its destination in ID/EX
//   ifid_rs, ifid_rt               source registers of the IF/ID instruction
//   pc_en                          PC load enable
//   *_en / *_flush                 per-latch enable / bubble (flush overrides en)
//   halted, stall_timeout          sticky status flags, registered
//   stall_cycles, redirects        perf counters (PIPELINE_PERF_CNT_EN only)
module pipeline_ctrl #(
  parameter int unsigned STALL_LIMIT = 1024
`ifdef PIPELINE_PERF_CNT_EN
  , parameter int unsigned CNT_W     = 32
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       exmem_dren,
  input  logic       exmem_dwen,
  input  logic       exmem_halt,
  input  logic       br_taken,
  input  logic       idex_dren,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       halted,
  output logic       stall_timeout
`ifdef PIPELINE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirects
`endif
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DSTALL = 2'd1;
  localparam logic [1:0] S_HALT   = 2'd2;

  localparam int unsigned      SC_W  = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0]  LIMIT = SC_W'(STALL_LIMIT);

  logic [1:0]      state, state_nxt;
  logic [SC_W-1:0] stall_cnt, stall_cnt_nxt;
  logic            memop, load_use;
  logic            fire_bubble;    // rules 1, 4, 5
  logic            fire_redirect;  // rule 3

  assign memop    = exmem_dren | exmem_dwen;
  assign load_use = idex_dren && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    state_nxt     = state;
    stall_cnt_nxt = '0;
    fire_bubble   = 1'b0;
    fire_redirect = 1'b0;

    if (state == S_HALT) begin
      stall_cnt_nxt = stall_cnt;
    end else if (memop && !dhit) begin
      memwb_flush   = 1'b1;
      state_nxt     = S_DSTALL;
      fire_bubble   = 1'b1;
      stall_cnt_nxt = (stall_cnt == LIMIT) ? stall_cnt : stall_cnt + 1'b1;
    end else if (exmem_halt) begin
      memwb_en  = 1'b1;
      state_nxt = S_HALT;
    end else if (br_taken) begin
      pc_en         = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      memwb_en      = 1'b1;
      state_nxt     = S_RUN;
      fire_redirect = 1'b1;
    end else if (load_use) begin
      // ID/EX gets one bubble while IF/ID and PC hold the dependent instruction
      idex_flush  = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      state_nxt   = S_RUN;
      fire_bubble = 1'b1;
    end else if (!ihit) begin
      ifid_flush  = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      state_nxt   = S_RUN;
      fire_bubble = 1'b1;
    end else begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      idex_en   = 1'b1;
      exmem_en  = 1'b1;
      memwb_en  = 1'b1;
      state_nxt = S_RUN;
    end

    // Reset forces bubbles everywhere regardless of state
    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_RUN;
      stall_cnt     <= '0;
      halted        <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      stall_cnt     <= stall_cnt_nxt;
      halted        <= halted | (state_nxt == S_HALT);
      stall_timeout <= stall_timeout | (stall_cnt_nxt == LIMIT);
    end
  end

`ifdef PIPELINE_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      redirects    <= '0;
    end else begin
      if (fire_bubble)   stall_cycles <= stall_cycles + 1'b1;
      if (fire_redirect) redirects    <= redirects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int LIM = 4;

  logic CLK, RST, ihit, dhit, exmem_dren, exmem_dwen, exmem_halt, br_taken, idex_dren;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, stall_timeout;
`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] stall_cycles, redirects;
`endif

  pipeline_ctrl #(.STALL_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen), .exmem_halt(exmem_halt),
    .br_taken(br_taken), .idex_dren(idex_dren), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halted(halted), .stall_timeout(stall_timeout)
`ifdef PIPELINE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .redirects(redirects)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic rst, ihit, dhit, dren, dwen, halt, br, idren;
    logic [4:0] idrt, rs, rt;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [10:0] exp;   // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush, halted, timeout}
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model state: only what is architecturally visible
  bit m_halted;
  bit m_to;
  int m_stall;
  logic [8:0] rule_bits [1:6];

  function automatic in_t mk_in(bit r, bit ih, bit dh, bit dr, bit dw, bit h, bit b,
                                bit idr, logic [4:0] idrt, logic [4:0] rs, logic [4:0] rt);
    in_t v;
    v.rst = r; v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw;
    v.halt = h; v.br = b; v.idren = idr; v.idrt = idrt; v.rs = rs; v.rt = rt;
    return v;
  endfunction

  function automatic int rule_of(in_t v);
    if ((v.dren || v.dwen) && !v.dhit) return 1;
    if (v.halt) return 2;
    if (v.br) return 3;
    if (v.idren && v.idrt != 0 && (v.idrt == v.rs || v.idrt == v.rt)) return 4;
    if (!v.ihit) return 5;
    return 6;
  endfunction

  function automatic logic [10:0] model_out(in_t v);
    if (v.rst) return 11'b00000_1111_0_0;
    if (m_halted) return {9'b0, 1'b1, m_to};
    return {rule_bits[rule_of(v)], 1'b0, m_to};
  endfunction

  function automatic void model_edge(in_t v);
    int r;
    if (v.rst) begin
      m_halted = 0; m_to = 0; m_stall = 0;
      return;
    end
    if (m_halted) return;
    r = rule_of(v);
    if (r == 1) begin
      if (m_stall < LIM) m_stall++;
      if (m_stall == LIM) m_to = 1;
    end else begin
      m_stall = 0;
    end
    if (r == 2) m_halted = 1;
  endfunction

  function automatic logic [10:0] observed();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, stall_timeout};
  endfunction

  task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", nm, got, exp);
    end
  endtask

  // One clock: drive at negedge, compare before the rising edge, advance model at edge
  task automatic step(input string nm, input in_t v, input bit use_model, input logic [10:0] exp);
    logic [10:0] e;
    @(negedge CLK);
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; exmem_dren = v.dren; exmem_dwen = v.dwen;
    exmem_halt = v.halt; br_taken = v.br; idex_dren = v.idren;
    idex_rt = v.idrt; ifid_rs = v.rs; ifid_rt = v.rt;
    #1;
    e = use_model ? model_out(v) : exp;
    check(nm, observed(), e);
    @(posedge CLK);
    model_edge(v);
  endtask

  vec_t tbl[$];

  initial begin
    in_t v;
    RST = 1'b1; ihit = 0; dhit = 0; exmem_dren = 0; exmem_dwen = 0; exmem_halt = 0;
    br_taken = 0; idex_dren = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    m_halted = 0; m_to = 0; m_stall = 0;
    rule_bits[1] = 9'b00000_0001;
    rule_bits[2] = 9'b00001_0000;
    rule_bits[3] = 9'b10001_1110;
    rule_bits[4] = 9'b00011_0100;
    rule_bits[5] = 9'b00111_1000;
    rule_bits[6] = 9'b11111_0000;

    //                      rst ih dh dr dw h b idr idrt rs rt
    tbl.push_back('{"reset",      mk_in(1,0,0,0,0,0,0,0, 0,0,0), 11'b00000_1111_00});
    tbl.push_back('{"run",        mk_in(0,1,0,0,0,0,0,0, 0,0,0), 11'b11111_0000_00});
    tbl.push_back('{"lu_rs",      mk_in(0,1,0,0,0,0,0,1, 5,5,2), 11'b00011_0100_00});
    tbl.push_back('{"lu_after",   mk_in(0,1,0,0,0,0,0,0, 5,5,2), 11'b11111_0000_00});
    tbl.push_back('{"lu_rt",      mk_in(0,1,0,0,0,0,0,1, 7,3,7), 11'b00011_0100_00});
    tbl.push_back('{"lu_r0",      mk_in(0,1,0,0,0,0,0,1, 0,0,0), 11'b11111_0000_00});
    tbl.push_back('{"lu_nomatch", mk_in(0,1,0,0,0,0,0,1, 6,5,4), 11'b11111_0000_00});
    tbl.push_back('{"imiss",      mk_in(0,0,0,0,0,0,0,0, 0,0,0), 11'b00111_1000_00});
    tbl.push_back('{"dstall1",    mk_in(0,1,0,1,0,0,0,0, 0,0,0), 11'b00000_0001_00});
    tbl.push_back('{"dstall2",    mk_in(0,1,0,1,0,0,1,0, 0,0,0), 11'b00000_0001_00});
    tbl.push_back('{"dstall3",    mk_in(0,0,0,1,0,0,0,1, 3,3,0), 11'b00000_0001_00});
    tbl.push_back('{"dhit_exit",  mk_in(0,1,1,1,0,0,0,0, 0,0,0), 11'b11111_0000_00});
    tbl.push_back('{"br_imiss",   mk_in(0,0,0,0,0,0,1,1, 4,4,4), 11'b10001_1110_00});
    tbl.push_back('{"br_over_lu", mk_in(0,1,1,1,0,0,1,1, 4,4,4), 11'b10001_1110_00});

    foreach (tbl[i]) step(tbl[i].name, tbl[i].in, 0, tbl[i].exp);

    // Stall timeout: sets after the LIM-th stall edge, survives dhit
    for (int i = 1; i <= 6; i++)
      step("timeout_stall", mk_in(0,1,0,0,1,0,0,0, 0,0,0), 0,
           {9'b00000_0001, 1'b0, (i > LIM) ? 1'b1 : 1'b0});
    step("timeout_exit", mk_in(0,1,1,0,1,0,0,0, 0,0,0), 0, 11'b11111_0000_01);

    // Halt: MEM/WB still retires the cycle HALT is seen, then everything freezes
    step("halt_enter", mk_in(0,1,1,0,0,1,0,0, 0,0,0), 0, 11'b00001_0000_01);
    for (int i = 0; i < 4; i++)
      step("halt_hold", mk_in(0,i[0],i[1],i[0],0,0,i[1],1, 1,1,1), 0, 11'b00000_0000_11);
    step("halt_reset", mk_in(1,1,1,0,0,0,0,0, 0,0,0), 0, 11'b00000_1111_00);
    step("post_halt",  mk_in(0,1,0,0,0,0,0,0, 0,0,0), 0, 11'b11111_0000_00);

    // Reset mid-stall must clear the consecutive-stall count
    for (int i = 0; i < 3; i++)
      step("pre_rst_stall", mk_in(0,1,0,1,0,0,0,0, 0,0,0), 0, 11'b00000_0001_00);
    step("mid_stall_rst", mk_in(1,1,0,1,0,0,0,0, 0,0,0), 0, 11'b00000_1111_00);
    for (int i = 0; i < 4; i++)
      step("post_rst_stall", mk_in(0,1,0,1,0,0,0,0, 0,0,0), 0, 11'b00000_0001_00);
    step("post_rst_stall5", mk_in(0,1,0,1,0,0,0,0, 0,0,0), 0, 11'b00000_0001_01);
    step("rst_again", mk_in(1,0,0,0,0,0,0,0, 0,0,0), 0, 11'b00000_1111_00);

    // Randomised run against the reference model
    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(0, 59) == 0);
      v.ihit  = ($urandom_range(0, 3) != 0);
      v.dhit  = ($urandom_range(0, 2) != 0);
      v.dren  = $urandom_range(0, 1);
      v.dwen  = ($urandom_range(0, 3) == 0);
      v.halt  = ($urandom_range(0, 24) == 0);
      v.br    = ($urandom_range(0, 5) == 0);
      v.idren = $urandom_range(0, 1);
      v.idrt  = 5'($urandom_range(0, 3));
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      step("random", v, 1, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
